crc32_mpeg2_checker: RTL

CRC32_MPEG2_CHECKER -- requirements
Module: crc32_mpeg2_checker

---
 rtl/crc32_mpeg2_checker.sv | 94 +++++++++
 1 files changed

// File: rtl/crc32_mpeg2_checker.sv
// crc32_mpeg2_checker: CRC-32/MPEG-2 frame checker that strips the 4-byte CRC trailer and reports per-frame status
module crc32_mpeg2_checker #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_sop,
  input  logic             s_eop,
  output logic             s_ready,
  output logic             m_valid,
  output logic [7:0]       m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             stat_valid,
  output logic             crc_ok,
  output logic             len_err,
  output logic [LEN_W-1:0] frame_len,
  output logic [LEN_W-1:0] frame_cnt,
  output logic [LEN_W-1:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, DATA, RESULT} state_t;
  state_t           state;
  logic [31:0]      crc, crc_next, dl;
  logic [2:0]       cnt;
  logic [LEN_W-1:0] len, len_next;
  logic             acc, start, take, fin, emit, bad;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {d, 24'h0};
    for (int i = 0; i < 8; i++) r = r[31] ? (r << 1) ^ 32'h04C11DB7 : r << 1;
    return r;
  endfunction

  // Handshake, next CRC/length and frame-boundary decode for the byte on the input
  always_comb begin
    s_ready  = !rst && state != RESULT && (!m_valid || m_ready);
    acc      = s_valid && s_ready;
    start    = acc && state == IDLE && s_sop;
    take     = start || (acc && state == DATA);
    fin      = take && s_eop;
    emit     = acc && state == DATA && cnt == 3'd4;
    crc_next = crc_upd(state == IDLE ? 32'hFFFF_FFFF : crc, s_data);
    len_next = state == IDLE ? LEN_W'(1) : (&len ? len : len + LEN_W'(1));
    bad      = crc_next != 32'h0 || len_next < LEN_W'(5);
  end

  // Frame FSM, 4-byte delay line holding back the CRC trailer, and registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      crc        <= 32'hFFFF_FFFF;
      len        <= '0;
      dl         <= '0;
      cnt        <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      stat_valid <= 1'b0;
      crc_ok     <= 1'b0;
      len_err    <= 1'b0;
      frame_len  <= '0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      stat_valid <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (emit) begin
        m_valid <= 1'b1;
        m_data  <= dl[31:24];
        m_last  <= s_eop;
      end
      if (state == RESULT) state <= IDLE;
      else if (fin) state <= RESULT;
      else if (start) state <= DATA;
      if (take) begin
        crc <= crc_next;
        len <= len_next;
        dl  <= start ? {24'h0, s_data} : {dl[23:0], s_data};
        cnt <= fin ? 3'd0 : start ? 3'd1 : cnt == 3'd4 ? cnt : cnt + 3'd1;
      end
      if (fin) begin
        stat_valid <= 1'b1;
        crc_ok     <= crc_next == 32'h0;
        len_err    <= len_next < LEN_W'(5);
        frame_len  <= len_next;
        frame_cnt  <= &frame_cnt ? frame_cnt : frame_cnt + LEN_W'(1);
        if (bad) err_cnt <= &err_cnt ? err_cnt : err_cnt + LEN_W'(1);
      end
    end
  end
endmodule
